// File: rtl/uart_rx_decoder.sv
// UART receiver: 2-flop synchronizer, mid-bit majority sampling, parity/stop
// checking and a receive FIFO with a registered head byte and sticky error flags.
module uart_rx_decoder #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             rx_in,
  input  logic [23:0]      baudcontrol,
  input  logic [1:0]       parity,
  input  logic             stop_sel,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [7:0]       dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overflow,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP1, STOP2, BRK} state_t;
  state_t state, state_n;

  logic rx_q1, rx_s, rx_sd;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) {rx_q1, rx_s, rx_sd} <= 3'b111;
    else       {rx_q1, rx_s, rx_sd} <= {rx_in, rx_q1, rx_s};

  logic [23:0] b_len, mid, tmr;
  logic [1:0]  smp;
  logic [7:0]  data;
  logic [2:0]  bit_idx;
  logic        fall, dec, bit_v, par_exp, perr_f, push_req;
  logic        shift, par_chk, last_ok, ferr_set;

  assign b_len   = (baudcontrol < 24'd4) ? 24'd4 : baudcontrol;
  assign mid     = b_len >> 1;
  assign fall    = rx_sd & ~rx_s;
  assign dec     = (state != IDLE) && (state != BRK) && (tmr == mid + 24'd1);
  assign bit_v   = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign par_exp = parity[0] ? ^data : ~^data;
  assign busy    = (state != IDLE);

  always_comb begin
    state_n  = state;
    shift    = 1'b0;
    par_chk  = 1'b0;
    last_ok  = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE:  if (fall) state_n = START;
      START: if (dec) state_n = bit_v ? IDLE : DATA;
      DATA:  if (dec) begin
        shift = 1'b1;
        if (bit_idx == 3'd7)
          state_n = (parity == 2'b01 || parity == 2'b10) ? PAR : STOP1;
      end
      PAR:   if (dec) begin
        par_chk = 1'b1;
        state_n = STOP1;
      end
      STOP1, STOP2: if (dec) begin
        if (!bit_v) begin
          ferr_set = 1'b1;
          state_n  = BRK;
        end else if (state == STOP1 && stop_sel) begin
          state_n = STOP2;
        end else begin
          last_ok = 1'b1;
          state_n = IDLE;
        end
      end
      BRK:   if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The detection cycle of the falling edge counts as timer tick 0.
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state    <= IDLE;
      tmr      <= '0;
      smp      <= 2'b11;
      data     <= '0;
      bit_idx  <= '0;
      perr_f   <= 1'b0;
      push_req <= 1'b0;
    end else begin
      state    <= state_n;
      push_req <= last_ok;
      if (state == IDLE)           tmr <= fall ? 24'd1 : 24'd0;
      else if (tmr == b_len - 24'd1) tmr <= '0;
      else                         tmr <= tmr + 24'd1;
      if (tmr == mid - 24'd1) smp[0] <= rx_s;
      if (tmr == mid)         smp[1] <= rx_s;
      if (state == IDLE) begin
        bit_idx <= '0;
        perr_f  <= 1'b0;
      end
      if (shift) begin
        data    <= {bit_v, data[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (par_chk) perr_f <= (bit_v != par_exp);
    end

  logic [CNT_W-1:0] wr_ptr, rd_ptr, rd_nx;
  logic [7:0]       mem [DEPTH];
  logic             do_pop, do_push, ovf_set;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == FULL_CNT);
  assign do_pop  = rd_en & ~empty;
  assign do_push = push_req & (~full | do_pop);
  assign ovf_set = push_req & full & ~do_pop;
  assign rd_nx   = rd_ptr + {{(CNT_W-1){1'b0}}, do_pop};

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;

  // Head register bypasses the byte being written into the slot about to become head.
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CNT_W'(1);
      rd_ptr <= rd_nx;
      if (do_push && rd_nx[AW-1:0] == wr_ptr[AW-1:0]) dout <= data;
      else if (rd_nx != wr_ptr)                       dout <= mem[rd_nx[AW-1:0]];
      parity_err <= (push_req & perr_f) | (parity_err & ~clr_err);
      frame_err  <= ferr_set | (frame_err & ~clr_err);
      overflow   <= ovf_set | (overflow & ~clr_err);
    end
endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed bench for uart_rx_decoder: a queue-based FIFO/flag model checked every
// cycle, plus literal expectations for the key points of each scenario.
module tb_uart_rx_decoder;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int B     = 26;

  logic             clk = 1'b0, nrst = 1'b0, rx_in = 1'b1;
  logic             stop_sel = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [23:0]      baudcontrol = 24'(B);
  logic [1:0]       parity = 2'b00;
  logic [7:0]       dout;
  logic             empty, full, parity_err, frame_err, overflow, busy;
  logic [CNT_W-1:0] count;

  int         total = 0, bad = 0;
  bit         chk_en = 1'b0;
  logic [7:0] mq[$];
  bit         m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .rx_in(rx_in), .baudcontrol(baudcontrol),
    .parity(parity), .stop_sel(stop_sel), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (chk_en && nrst) begin
      chk("m_empty", empty, mq.size() == 0);
      chk("m_count", count, mq.size());
      chk("m_full", full, mq.size() == DEPTH);
      if (mq.size() > 0) chk("m_dout", dout, mq[0]);
      chk("m_perr", parity_err, m_perr);
      chk("m_ferr", frame_err, m_ferr);
      chk("m_ovf", overflow, m_ovf);
    end

  task automatic m_push(input logic [7:0] d);
    if (mq.size() >= DEPTH) m_ovf = 1'b1;
    else mq.push_back(d);
  endtask

  // pmode: 0 none, 1 even, 2 odd. rdw holds rd_en across the +-2 window of the push.
  task automatic send_frame(input logic [7:0] d, input int pmode, input bit pbad,
                            input int nstop, input bit stop_bad, input bit rdw, input bit lat_chk);
    logic [11:0]      fr;
    int               nb, nom, lat;
    logic [CNT_W-1:0] cnt0;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[1+i] = d[i];
    nb = 9;
    if (pmode != 0) begin
      fr[nb] = ((pmode == 1) ? ^d : ~^d) ^ pbad;
      nb++;
    end
    for (int s = 0; s < nstop; s++) begin
      fr[nb] = (s == nstop - 1) ? ~stop_bad : 1'b1;
      nb++;
    end
    nom  = 2 + ((2 * nb - 1) * B) / 2;
    lat  = -1;
    cnt0 = count;
    for (int c = 0; c < nb * B; c++) begin
      if (c >= (nb - 1) * B) chk_en = 1'b0;
      if (lat < 0 && c > 0 && count != cnt0) lat = c - 1;
      rx_in = fr[c / B];
      rd_en = rdw && (c >= nom - 2) && (c <= nom + 2);
      @(negedge clk);
    end
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    if (lat_chk) begin
      total++;
      if (lat < nom - 2 || lat > nom + 2) begin
        bad++;
        $display("FAIL latency: got %0d want %0d+-2", lat, nom);
      end
    end
    if (rdw) repeat (5) if (mq.size() > 0) void'(mq.pop_front());
    if (stop_bad) m_ferr = 1'b1;
    else begin
      if (pmode != 0 && pbad) m_perr = 1'b1;
      m_push(d);
    end
    chk_en = 1'b1;
  endtask

  task automatic pop1(output logic [7:0] v);
    v = dout;
    rd_en = 1'b1;
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clr1();
    clr_err = 1'b1;
    @(posedge clk);
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {parity_err, frame_err, overflow}, 0);
    nrst = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk_en = 1'b1;

    // 8N1 single byte, then pop
    send_frame(8'h55, 0, 0, 1, 0, 0, 1);
    chk("t1_dout", dout, 8'h55);
    chk("t1_count", count, 1);
    pop1(v);
    chk("t1_empty", empty, 1);
    chk("t1_count0", count, 0);

    // even parity: good then bad parity bit
    parity = 2'b01;
    repeat (2) @(negedge clk);
    send_frame(8'hA5, 1, 0, 1, 0, 0, 1);
    chk("t2_perr_lo", parity_err, 0);
    send_frame(8'hA5, 1, 1, 1, 0, 0, 0);
    chk("t2_count", count, 2);
    chk("t2_perr_hi", parity_err, 1);
    clr1();
    chk("t2_perr_clr", parity_err, 0);
    pop1(v); chk("t2_rd0", v, 8'hA5);
    pop1(v); chk("t2_rd1", v, 8'hA5);
    parity = 2'b00;

    // two stop bits, second one low, then a long break
    stop_sel = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h3C, 0, 0, 2, 1, 0, 0);
    chk("t3_ferr", frame_err, 1);
    chk("t3_count", count, 0);
    repeat (5 * B) @(negedge clk);
    chk("t3_brk_busy", busy, 1);
    rx_in = 1'b1;
    repeat (2 * B) @(negedge clk);
    chk("t3_idle", busy, 0);
    send_frame(8'h3C, 0, 0, 2, 0, 0, 1);
    chk("t3_dout", dout, 8'h3C);
    pop1(v);
    clr1();
    stop_sel = 1'b0;
    repeat (2) @(negedge clk);

    // 5-cycle low glitch on idle line
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_busy_hi", busy, 1);
    rx_in = 1'b1;
    repeat (B - 5) @(negedge clk);
    chk("t4_busy_lo", busy, 0);
    repeat (B) @(negedge clk);

    // 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 0, 0, 1, 0, 0, 0);
      if (i == 15) chk("t5_full", full, 1);
    end
    chk("t5_ovf", overflow, 1);
    chk("t5_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      pop1(v);
      chk("t5_order", v, i);
    end
    chk("t5_empty", empty, 1);
    clr1();
    chk("t5_ovf_clr", overflow, 0);
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 0, 0, 1, 0, 0, 0);
    chk("t5_full2", full, 1);
    send_frame(8'h30, 0, 0, 1, 0, 1, 0);
    chk("t5_no_ovf", overflow, 0);
    chk("t5_count2", count, 12);
    chk("t5_head2", dout, 8'h25);

    // reset in the middle of DATA, then a clean frame
    rx_in = 1'b0; repeat (B) @(negedge clk);
    rx_in = 1'b1; repeat (B) @(negedge clk);
    rx_in = 1'b0; repeat (2 * B) @(negedge clk);
    chk_en = 1'b0;
    nrst = 1'b0;
    mq.delete();
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_flags", {parity_err, frame_err, overflow}, 0);
    rx_in = 1'b1;
    nrst = 1'b1;
    repeat (2 * B) @(negedge clk);
    chk_en = 1'b1;
    send_frame(8'h81, 0, 0, 1, 0, 0, 1);
    chk("t6_dout", dout, 8'h81);
    chk("t6_count", count, 1);
    chk("t6_flags", {parity_err, frame_err, overflow}, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_decoder.md
Name: uart_rx_decoder

Overview:
UART receive front end for the peripheral subsystem. It samples the asynchronous RX pin (ck_io8 at top level), recovers framed bytes using a programmable bit period, checks parity and stop bits, and pushes good bytes into an internal receive FIFO. The core-side RX buffer/CSR logic drains the FIFO. Its framing settings (baudcontrol, parity, stop_sel) match those of the UART Encoder.

Parameters:
DEPTH, 16, FIFO entries (power of 2, ≥2)
CNT_W, 5, width of count output (log2(DEPTH)+1)

Ports:
clk  in  1  system clock
nrst  in  1  async active-low reset
rx_in  in  1  asynchronous serial input, idle high
baudcontrol  in  24  clk cycles per bit (valid ≥4; values <4 are treated as 4)
parity  in  2  00 none, 01 even, 10 odd, 11 none
stop_sel  in  1  0 one stop bit, 1 two stop bits
rd_en  in  1  pop request
clr_err  in  1  clears sticky flags
dout  out  8  FIFO head byte (valid while !empty)
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  CNT_W  bytes held
parity_err  out  1  sticky
frame_err  out  1  sticky
overflow  out  1  sticky
busy  out  1  high while state != IDLE

Behaviour:
- Reset (async, nrst=0): state IDLE, FIFO pointers 0, dout=0, empty=1, full=0, count=0, all sticky flags 0, busy=0. Synchronizer flops are set to 1. Reset mid-frame discards the partial byte.
- rx_in passes through a 2-flop synchronizer (rx_s), which adds 2 cycles of latency. All timing below refers to rx_s.
- Bit timer: counter runs 0..B-1, where B=max(baudcontrol,4). Mid = B>>1. Bit value = majority of rx_s sampled at Mid-1, Mid, Mid+1. The bit decision is taken at Mid+1.
- FSM:
  - IDLE: a 1→0 transition on rx_s moves to START with timer=0. A low level alone, without the edge, does not start a frame.
  - START: at decision, 0→DATA (bit index 0); 1→IDLE (glitch rejected, nothing flagged).
  - DATA: 8 bits, LSB first, shifted into the data register. After bit 7: PARITY if parity∈{01,10}, else STOP1.
  - PARITY: even → expected bit = ^data; odd → expected bit = ~^data. A mismatch sets the internal perr for this frame.
  - STOP1: decision 1 → if stop_sel, go to STOP2; else complete. Decision 0 → frame_err=1, byte discarded, go to BREAK.
  - STOP2: same rule as STOP1.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a low line from retriggering the receiver.
  - Complete: the push request is asserted in the cycle after the final stop decision, and the FSM returns to IDLE in that same cycle. It does not wait for the rest of the stop bit.
- A frame with a parity error is still pushed, and parity_err is set.
- Config inputs are sampled continuously. Changing them mid-frame is undefined; software changes them only while busy=0.
- FIFO:
  - Pop: rd_en && !empty advances the read pointer. dout shows the new head the next cycle (registered head).
  - rd_en when empty is ignored.
  - Push when full and no pop in the same cycle: the byte is dropped and overflow=1.
  - Push and pop in the same cycle: both happen, even when full; count is unchanged.
  - Pointers wrap modulo DEPTH. count = wr-rd, using an extra MSB.
- Sticky flags: set by the events above; cleared by clr_err in one cycle. If a set event and clr_err coincide, set wins.
- Byte latency (nominal): the push occurs about 2 + 9.5·B cycles (8N1) after the falling edge of rx_in. Bench checks allow ±2 cycles.

Test Plan:
- B=26, 8N1, send 0x55 → one push; dout=0x55, count=1, empty=0, no flags. Then rd_en=1 for one cycle → empty=1, count=0.
- B=26, even parity, send 0xA5 with parity bit 0 (correct) then 0xA5 with parity bit 1 → both bytes are queued (count=2); parity_err rises only after the second frame. Then clr_err → parity_err=0.
- stop_sel=1, send 0x3C with the second stop bit forced 0 → frame_err=1, count remains 0. Hold rx_in low for 5·B cycles → no further pushes; after rx_in returns high, send 0x3C correctly → dout=0x3C.
- Low glitch of 5 cycles on an idle line (B=26) → stays/returns IDLE, busy drops within B cycles, no push, no flags.
- Send 17 bytes 0x00..0x10 without reading → full=1 after 16, overflow=1, and 0x10 is lost. Read 16 → values 0x00..0x0F in order, then empty=1. Repeat while issuing rd_en on the push cycle at full → no overflow.
- Deassert nrst mid-DATA of a frame, then release and send 0x81 → only 0x81 is received; all flags are 0.
